// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - byte FIFOs between the host registers and the UART core
// TX FIFO drains through a send/sent/idle-gap FSM; RX FIFO captures received bytes.
module uart_fifo #(
  parameter int ADDR_WIDTH    = 4,
  parameter int UART_IDLE_GAP = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            tx_data,
  input  logic                  tx_write,
  output logic                  tx_full,
  output logic                  tx_empty,
  output logic [ADDR_WIDTH:0]   tx_level,
  output logic [7:0]            rx_data,
  input  logic                  rx_read,
  output logic                  rx_empty,
  output logic [ADDR_WIDTH:0]   rx_level,
  output logic                  rx_overflow,
  input  logic                  ovf_clear,
  output logic [7:0]            uart_data_in,
  output logic                  uart_send,
  input  logic                  uart_sent,
  input  logic [7:0]            uart_data_out,
  input  logic                  uart_received
);

  localparam int DEPTH_I = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(DEPTH_I);
  localparam int GW = (UART_IDLE_GAP > 1) ? $clog2(UART_IDLE_GAP) : 1;
  localparam logic [GW-1:0] GAP_INIT = GW'(UART_IDLE_GAP - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_SENT, GAP} tx_state_t;

  tx_state_t               state_q, state_d;
  logic [GW-1:0]           gap_q, gap_d;
  logic [7:0]              data_in_q, data_in_d;

  logic [7:0]              tx_mem_q [DEPTH_I];
  logic [ADDR_WIDTH-1:0]   tx_wr_ptr_q, tx_rd_ptr_q;
  logic [ADDR_WIDTH:0]     tx_count_q, tx_count_d;
  logic                    tx_full_q, tx_empty_q;
  logic                    tx_push, tx_pop;

  logic [7:0]              rx_mem_q [DEPTH_I];
  logic [ADDR_WIDTH-1:0]   rx_wr_ptr_q, rx_rd_ptr_q;
  logic [ADDR_WIDTH:0]     rx_count_q, rx_count_d;
  logic                    rx_full_q, rx_empty_q, ovf_q;
  logic                    rx_push, rx_pop, rx_drop;

  // Full/empty decisions use the registered (pre-edge) flags only.
  assign tx_push = tx_write && !tx_full_q;
  assign tx_pop  = (state_q == IDLE) && !tx_empty_q;
  assign rx_push = uart_received && !rx_full_q;
  assign rx_drop = uart_received && rx_full_q;
  assign rx_pop  = rx_read && !rx_empty_q;

  always_comb begin
    tx_count_d = tx_count_q;
    unique case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + 1'b1;
      2'b01:   tx_count_d = tx_count_q - 1'b1;
      default: tx_count_d = tx_count_q;
    endcase
  end

  always_comb begin
    rx_count_d = rx_count_q;
    unique case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + 1'b1;
      2'b01:   rx_count_d = rx_count_q - 1'b1;
      default: rx_count_d = rx_count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_ptr_q] <= tx_data;
    if (rx_push) rx_mem_q[rx_wr_ptr_q] <= uart_data_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      tx_full_q   <= 1'b0;
      tx_empty_q  <= 1'b1;
    end else begin
      if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + 1'b1;
      if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + 1'b1;
      tx_count_q <= tx_count_d;
      tx_full_q  <= (tx_count_d == DEPTH);
      tx_empty_q <= (tx_count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
      rx_full_q   <= 1'b0;
      rx_empty_q  <= 1'b1;
      ovf_q       <= 1'b0;
    end else begin
      if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + 1'b1;
      if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + 1'b1;
      rx_count_q <= rx_count_d;
      rx_full_q  <= (rx_count_d == DEPTH);
      rx_empty_q <= (rx_count_d == '0);
      // A fresh drop takes priority over a clear in the same cycle.
      if (rx_drop)        ovf_q <= 1'b1;
      else if (ovf_clear) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gap_q     <= '0;
      data_in_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      data_in_q <= data_in_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    data_in_d = data_in_q;
    unique case (state_q)
      IDLE: begin
        if (!tx_empty_q) begin
          data_in_d = tx_mem_q[tx_rd_ptr_q];
          state_d   = SEND;
        end
      end
      SEND: state_d = WAIT_SENT;
      WAIT_SENT: begin
        if (uart_sent) begin
          gap_d   = GAP_INIT;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // The send strobe is a pure state decode, so no input reaches it combinationally.
  assign uart_send    = (state_q == SEND);
  assign uart_data_in = data_in_q;

  assign tx_full     = tx_full_q;
  assign tx_empty    = tx_empty_q;
  assign tx_level    = tx_count_q;
  assign rx_empty    = rx_empty_q;
  assign rx_level    = rx_count_q;
  assign rx_overflow = ovf_q;
  assign rx_data     = rx_mem_q[rx_rd_ptr_q];

endmodule

// File: tb/tb_uart_fifo.sv
// tb/tb_uart_fifo.sv - self-checking bench for uart_fifo
// Queue/cycle-count model compared every cycle, plus directed literal checks.
module tb_uart_fifo;

  localparam int AW    = 4;
  localparam int GAP   = 24;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  tx_data = '0;
  logic        tx_write = 1'b0;
  logic        tx_full, tx_empty;
  logic [AW:0] tx_level;
  logic [7:0]  rx_data;
  logic        rx_read = 1'b0;
  logic        rx_empty;
  logic [AW:0] rx_level;
  logic        rx_overflow;
  logic        ovf_clear = 1'b0;
  logic [7:0]  uart_data_in;
  logic        uart_send;
  logic        uart_sent = 1'b0;
  logic [7:0]  uart_data_out = '0;
  logic        uart_received = 1'b0;

  always #5 clk = ~clk;

  uart_fifo #(.ADDR_WIDTH(AW), .UART_IDLE_GAP(GAP)) dut (
    .clk(clk), .rst(rst),
    .tx_data(tx_data), .tx_write(tx_write), .tx_full(tx_full),
    .tx_empty(tx_empty), .tx_level(tx_level),
    .rx_data(rx_data), .rx_read(rx_read), .rx_empty(rx_empty),
    .rx_level(rx_level), .rx_overflow(rx_overflow), .ovf_clear(ovf_clear),
    .uart_data_in(uart_data_in), .uart_send(uart_send), .uart_sent(uart_sent),
    .uart_data_out(uart_data_out), .uart_received(uart_received)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: byte queues plus cycle arithmetic for when the next byte may leave.
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [7:0] m_data_in;
  bit         m_send, m_busy, m_ovf, m_valid;
  int         m_ready, m_send_cyc;
  int         cyc = 0;
  bit         t_pop, t_txfull, t_rxfull, t_rxempty;

  always @(posedge clk) begin
    if (rst) begin
      txq.delete();
      rxq.delete();
      m_data_in = 8'h00;
      m_send = 0; m_busy = 0; m_ovf = 0; m_ready = 0; m_send_cyc = 0;
      m_valid = 1;
    end else if (m_valid) begin
      t_txfull  = (txq.size() == DEPTH);
      t_pop     = !m_busy && (cyc >= m_ready) && (txq.size() > 0);
      if (m_busy && uart_sent && cyc > m_send_cyc) begin
        m_busy  = 0;
        m_ready = cyc + GAP + 1;
      end
      if (t_pop) begin
        m_data_in  = txq.pop_front();
        m_busy     = 1;
        m_send_cyc = cyc + 1;
      end
      if (tx_write && !t_txfull) txq.push_back(tx_data);
      m_send = t_pop;

      t_rxfull  = (rxq.size() == DEPTH);
      t_rxempty = (rxq.size() == 0);
      if (rx_read && !t_rxempty) void'(rxq.pop_front());
      if (ovf_clear) m_ovf = 0;
      if (uart_received) begin
        if (!t_rxfull) rxq.push_back(uart_data_out);
        else           m_ovf = 1;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("tx_full",      tx_full,      txq.size() == DEPTH);
      chk("tx_empty",     tx_empty,     txq.size() == 0);
      chk("tx_level",     tx_level,     txq.size());
      chk("rx_empty",     rx_empty,     rxq.size() == 0);
      chk("rx_level",     rx_level,     rxq.size());
      chk("rx_overflow",  rx_overflow,  m_ovf);
      chk("uart_send",    uart_send,    m_send);
      chk("uart_data_in", uart_data_in, m_data_in);
      if (rxq.size() > 0) chk("rx_data", rx_data, rxq[0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_send(output int c);
    c = -1;
    for (int i = 0; i < 200; i++) begin
      if (uart_send === 1'b1) begin
        c = cyc;
        break;
      end
      tick();
    end
    if (c < 0) chk("send_timeout", 0, 1);
  endtask

  task automatic pulse_sent(output int s);
    uart_sent = 1'b1;
    s = cyc;
    tick();
    uart_sent = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] b);
    uart_data_out = b;
    uart_received = 1'b1;
    tick();
    uart_received = 1'b0;
  endtask

  int w, c, s, last, n;

  initial begin
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_tx_empty", tx_empty, 1);
    chk("rst_tx_level", tx_level, 0);
    chk("rst_rx_empty", rx_empty, 1);
    chk("rst_send", uart_send, 0);
    chk("rst_data_in", uart_data_in, 0);

    // single byte: send two cycles after the write
    tx_data = 8'hA5; tx_write = 1'b1; w = cyc;
    tick();
    tx_write = 1'b0;
    wait_send(c);
    chk("t1_latency", c - w, 2);
    chk("t1_data", uart_data_in, 8'hA5);
    tick();
    chk("t1_empty_after", tx_empty, 1);
    n = 0;
    repeat (98) begin
      if (uart_send) n++;
      tick();
    end
    chk("t1_single_pulse", n, 0);
    pulse_sent(s);

    // three bytes queued during the idle gap
    for (int b = 1; b <= 3; b++) begin
      tx_data = 8'(b); tx_write = 1'b1;
      tick();
    end
    tx_write = 1'b0;
    chk("t2_level3", tx_level, 3);
    last = s;
    for (int k = 0; k < 3; k++) begin
      wait_send(c);
      chk("t2_data", uart_data_in, k + 1);
      chk("t2_gap_min", (c - last) >= GAP + 2, 1);
      if (k == 0) chk("t2_first_gap", c - last, GAP + 2);
      repeat (5) tick();
      pulse_sent(last);
    end

    // overfill TX while the first byte is in flight, across pointer wrap
    repeat (40) tick();
    for (int i = 0; i < 20; i++) begin
      tx_data = 8'h30 + 8'(i); tx_write = 1'b1;
      tick();
    end
    tx_write = 1'b0;
    chk("t3_full", tx_full, 1);
    chk("t3_level", tx_level, 16);
    chk("t3_inflight", uart_data_in, 8'h30);
    pulse_sent(s);
    for (int k = 1; k <= 16; k++) begin
      wait_send(c);
      chk("t3_order", uart_data_in, 8'h30 + 8'(k));
      repeat (3) tick();
      pulse_sent(s);
    end
    n = 0;
    repeat (40) begin
      if (uart_send) n++;
      tick();
    end
    chk("t3_rejected", n, 0);
    chk("t3_drained", tx_empty, 1);

    // RX fill, overflow, drain
    for (int i = 0; i < 16; i++) rx_push(8'h11 + 8'(i));
    chk("t4_level16", rx_level, 16);
    chk("t4_no_ovf", rx_overflow, 0);
    rx_push(8'h55);
    chk("t4_ovf", rx_overflow, 1);
    chk("t4_level_kept", rx_level, 16);
    for (int k = 0; k < 16; k++) begin
      chk("t4_rx_order", rx_data, 8'h11 + 8'(k));
      rx_read = 1'b1;
      tick();
      rx_read = 1'b0;
    end
    chk("t4_rx_empty", rx_empty, 1);
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    chk("t4_ovf_clear", rx_overflow, 0);

    // simultaneous pop and push; pop on empty
    rx_push(8'h66);
    chk("t5_level1", rx_level, 1);
    rx_read = 1'b1; uart_data_out = 8'h77; uart_received = 1'b1;
    tick();
    rx_read = 1'b0; uart_received = 1'b0;
    chk("t5_level_same", rx_level, 1);
    chk("t5_head77", rx_data, 8'h77);
    rx_read = 1'b1; tick(); rx_read = 1'b0;
    chk("t5_empty", rx_empty, 1);
    rx_read = 1'b1; tick(); rx_read = 1'b0;
    chk("t5_empty_read", rx_level, 0);
    rx_push(8'h88);
    chk("t5_head88", rx_data, 8'h88);

    // overflow set beats a same-cycle clear
    for (int i = 0; i < 16; i++) rx_push(8'hA0 + 8'(i));
    chk("t5_ovf_set", rx_overflow, 1);
    ovf_clear = 1'b1;
    rx_push(8'hEE);
    ovf_clear = 1'b0;
    chk("t5_set_wins", rx_overflow, 1);

    // reset while waiting for sent with bytes queued
    for (int i = 0; i < 5; i++) begin
      tx_data = 8'hC0 + 8'(i); tx_write = 1'b1;
      tick();
    end
    tx_write = 1'b0;
    repeat (2) tick();
    chk("t6_queued", tx_level, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_tx_empty", tx_empty, 1);
    chk("t6_send", uart_send, 0);
    chk("t6_ovf", rx_overflow, 0);
    chk("t6_data_in", uart_data_in, 0);
    chk("t6_rx_empty", rx_empty, 1);
    n = 0;
    repeat (60) begin
      if (uart_send) n++;
      tick();
    end
    chk("t6_no_send", n, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/uart_fifo.md
Name: uart_fifo

Overview:
- Byte-buffering front end for the UART core; sits between the system-bus register interface and the UART core's byte handshake.
- A TX FIFO accepts bytes from the host and feeds them to the UART one at a time using the UART's send/sent handshake and its post-frame idle gap.
- An RX FIFO captures every byte the UART reports received, for the host to pop later.

Parameters:
- ADDR_WIDTH, 4: FIFO address width. Each FIFO has depth 2**ADDR_WIDTH.
- UART_IDLE_GAP, 24: cycles the UART core needs after its sent pulse before it accepts a new byte. Equals CLK_FREQ/(BAUD_RATE*OVER_SAMP) of the attached UART.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- tx_data  in  8  byte to enqueue for transmission.
- tx_write  in  1  enqueue strobe. Ignored when tx_full.
- tx_full  out  1  TX FIFO full.
- tx_empty  out  1  TX FIFO empty.
- tx_level  out  ADDR_WIDTH+1  TX occupancy.
- rx_data  out  8  head of RX FIFO (show-ahead). Valid when !rx_empty.
- rx_read  in  1  pop strobe. Ignored when rx_empty.
- rx_empty  out  1  RX FIFO empty.
- rx_level  out  ADDR_WIDTH+1  RX occupancy.
- rx_overflow  out  1  sticky flag: a received byte was dropped.
- ovf_clear  in  1  clears rx_overflow.
- uart_data_in  out  8  byte presented to the UART core.
- uart_send  out  1  one-cycle send pulse to the UART core.
- uart_sent  in  1  UART core's one-cycle frame-done pulse.
- uart_data_out  in  8  UART core's received byte.
- uart_received  in  1  UART core's one-cycle byte-received pulse.

Behaviour:
- Reset (and initial state):
  - FIFOs empty, pointers 0.
  - tx_full=0, tx_empty=1, rx_empty=1, both levels 0.
  - rx_overflow=0, uart_send=0, uart_data_in=0, TX FSM in IDLE.
  - Reset mid-frame discards all FIFO contents. The UART core shares rst, so both blocks restart together.
- FIFOs:
  - Circular buffers with ADDR_WIDTH-bit pointers that wrap modulo depth. Occupancy counter is ADDR_WIDTH+1 bits.
  - Full = count==depth; empty = count==0. Flags and levels are registered and reflect the state after the last clock edge.
  - Full/empty are evaluated on pre-edge state.
  - A write while full is rejected even if a pop occurs the same cycle.
  - A simultaneous accepted write and pop leaves the count unchanged.
  - rx_data is a combinational read at the RX read pointer.
- TX FSM states: IDLE, SEND, WAIT_SENT, GAP.
  - IDLE: if !tx_empty, pop head into uart_data_in, go to SEND.
  - SEND: uart_send=1 for exactly this cycle; uart_data_in stays stable. Go to WAIT_SENT.
  - WAIT_SENT: uart_send=0. On uart_sent=1, load gap counter with UART_IDLE_GAP-1 and go to GAP.
  - GAP: decrement the counter; at 0 go to IDLE.
  - Net effect: the next uart_send occurs no earlier than UART_IDLE_GAP+2 cycles after the uart_sent pulse.
  - uart_data_in holds the last byte until the next pop.
- TX latency: tx_write in cycle N to an empty FIFO with the FSM in IDLE gives uart_send=1 in cycle N+2. The FIFO returns to empty at the N+2 edge.
- RX path:
  - uart_received=1 while RX not full: write uart_data_out at the next edge.
  - uart_received=1 while full: byte dropped, rx_overflow set, FIFO contents unchanged.
  - ovf_clear and a new overflow in the same cycle: set wins.
- No combinational path from any input to uart_send.

Test Plan:
- Write 0xA5 after reset (tx_write one cycle) -> uart_send pulses exactly once, 2 cycles later, with uart_data_in=0xA5; tx_empty=1 afterwards. Bench returns uart_sent 100 cycles later -> FSM idle after UART_IDLE_GAP+1 cycles.
- Write 0x01,0x02,0x03 back-to-back -> tx_level reaches 3. Three uart_send pulses in order 0x01,0x02,0x03; each pulse comes ≥UART_IDLE_GAP+2 cycles after the previous uart_sent; no pulse occurs while in WAIT_SENT.
- Fill TX with 16 bytes (ADDR_WIDTH=4) while uart_sent is held off -> tx_full=1 with 16 entries (head popped; FIFO holds 15 plus one in flight, then accepts 1 more). A 17th write is rejected; the byte sequence out equals the input order across pointer wrap.
- Pulse uart_received with 0x11..0x20 (16 bytes), no reads -> rx_level=16 and rx_full behaviour holds. A 17th byte 0x55 sets rx_overflow; reading all 16 returns 0x11..0x20. ovf_clear -> rx_overflow=0.
- With RX holding 1 byte, assert rx_read and uart_received(0x77) in the same cycle -> rx_level stays 1 and rx_data=0x77. rx_read on empty -> no pointer change.
- Assert rst during WAIT_SENT with 5 bytes queued -> next cycle tx_empty=1, uart_send=0, FSM IDLE, rx_overflow=0. No further uart_send until a new write.
